// File: rtl/config_router_pkg.sv
// Shared configuration-path constants and types.
//   - Config IDs of the existing consumers (flow table, timestamp, rate limiter)
//   - Flit geometry (width, config_id position and width)
//   - Default channel-to-ID map and the broadcast ID used by config_router
//   - config_flit_t, the typed view of a flit used by instantiating top levels
package config_router_pkg;

    localparam int CONFIG_FLIT_WIDTH   = 512;
    localparam int CONFIG_ID_LSB       = 480;
    localparam int CONFIG_ID_WIDTH     = 32;
    localparam int NUM_CONFIG_CHANNELS = 3;

    localparam logic [CONFIG_ID_WIDTH-1:0] FLOW_TABLE_CONFIG_ID = 32'h0000_0101;
    localparam logic [CONFIG_ID_WIDTH-1:0] TIMESTAMP_CONFIG_ID  = 32'h0000_0202;
    localparam logic [CONFIG_ID_WIDTH-1:0] RATE_LIMIT_CONFIG_ID = 32'h0000_0303;
    localparam logic [CONFIG_ID_WIDTH-1:0] CONFIG_BROADCAST_ID  = 32'hFFFF_FFFF;

    // Channel k's ID lives in slice k, so channel 0 is the lowest slice.
    localparam logic [NUM_CONFIG_CHANNELS*CONFIG_ID_WIDTH-1:0] DEFAULT_CHANNEL_ID_MAP =
        {RATE_LIMIT_CONFIG_ID, TIMESTAMP_CONFIG_ID, FLOW_TABLE_CONFIG_ID};

    typedef struct packed {
        logic [CONFIG_ID_WIDTH-1:0]                   config_id;
        logic [CONFIG_FLIT_WIDTH-CONFIG_ID_WIDTH-1:0] payload;
    } config_flit_t;

endpackage

// File: rtl/config_fifo.sv
// Per-channel buffer for config_router.
//   clk, rst_n           : clock, asynchronous active-low reset (pointers only)
//   push, push_data      : write request and flit; ignored while full
//   full                 : registered-pointer full flag
//   pop                  : consumer ready; pops only while valid
//   pop_data, valid      : head entry and its valid; no fall-through, so a
//                          pushed entry is visible the cycle after the push
module config_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal means empty, differing only
    // in the wrap bit means full.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    assign valid    = !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed while valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/config_router.sv
// Routes configuration flits to NUM_CHANNELS consumers by config_id.
//   clk, rst                        : clock, asynchronous active-low reset
//   in_config_data/valid/ready      : input flit stream (one flit per beat)
//   out_data/valid/ready            : per-channel valid/ready streams, slice k
//   stats_clear                     : synchronous clear of counters and error
//   drop_count                      : saturating count of unknown-ID flits
//   accept_count                    : saturating per-channel push count, slice k
//   err_unknown_id                  : sticky flag, set on the first drop
module config_router
    import config_router_pkg::*;
#(
    parameter int                                NUM_CHANNELS   = NUM_CONFIG_CHANNELS,
    parameter int                                FLIT_WIDTH     = CONFIG_FLIT_WIDTH,
    parameter int                                ID_LSB         = CONFIG_ID_LSB,
    parameter int                                ID_WIDTH       = CONFIG_ID_WIDTH,
    parameter logic [NUM_CHANNELS*ID_WIDTH-1:0]  CHANNEL_ID_MAP = DEFAULT_CHANNEL_ID_MAP,
    parameter logic [ID_WIDTH-1:0]               BROADCAST_ID   = CONFIG_BROADCAST_ID,
    parameter int                                FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLIT_WIDTH-1:0]            in_config_data,
    input  logic                             in_config_valid,
    output logic                             in_config_ready,
    output logic [NUM_CHANNELS*FLIT_WIDTH-1:0] out_data,
    output logic [NUM_CHANNELS-1:0]          out_valid,
    input  logic [NUM_CHANNELS-1:0]          out_ready,
    input  logic                             stats_clear,
    output logic [31:0]                      drop_count,
    output logic [NUM_CHANNELS*32-1:0]       accept_count,
    output logic                             err_unknown_id
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [ID_WIDTH-1:0]        cfg_id;
    logic [NUM_CHANNELS-1:0]    target;
    logic [NUM_CHANNELS-1:0]    fifo_full;
    logic [NUM_CHANNELS-1:0]    push;
    logic                       bcast;
    logic                       unknown;
    logic                       accept;

    logic [31:0]                drop_count_q, drop_count_d;
    logic                       err_unknown_id_q, err_unknown_id_d;
    logic [NUM_CHANNELS*32-1:0] accept_count_q, accept_count_d;

    assign cfg_id = in_config_data[ID_LSB +: ID_WIDTH];

    // Ready looks only at registered full flags of the targeted channels, so
    // it never depends on out_ready and a multi-target flit goes everywhere
    // or nowhere. Unknown IDs are always taken so they cannot block the input.
    always_comb begin
        bcast = (cfg_id == BROADCAST_ID);
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            target[k] = bcast || (cfg_id == CHANNEL_ID_MAP[k*ID_WIDTH +: ID_WIDTH]);
        end
        unknown         = ~|target;
        in_config_ready = unknown || (&(~(target & fifo_full)));
        accept          = in_config_valid && in_config_ready;
        push            = accept ? target : '0;
    end

    // stats_clear wins over any increment in the same cycle.
    always_comb begin
        drop_count_d     = drop_count_q;
        err_unknown_id_d = err_unknown_id_q;
        accept_count_d   = accept_count_q;
        if (stats_clear) begin
            drop_count_d     = '0;
            err_unknown_id_d = 1'b0;
            accept_count_d   = '0;
        end else begin
            if (accept && unknown) begin
                drop_count_d     = sat_inc(drop_count_q);
                err_unknown_id_d = 1'b1;
            end
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (push[k]) begin
                    accept_count_d[k*32 +: 32] = sat_inc(accept_count_q[k*32 +: 32]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count_q     <= '0;
            err_unknown_id_q <= 1'b0;
            accept_count_q   <= '0;
        end else begin
            drop_count_q     <= drop_count_d;
            err_unknown_id_q <= err_unknown_id_d;
            accept_count_q   <= accept_count_d;
        end
    end

    assign drop_count     = drop_count_q;
    assign err_unknown_id = err_unknown_id_q;
    assign accept_count   = accept_count_q;

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        config_fifo #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst),
            .push      (push[k]),
            .push_data (in_config_data),
            .full      (fifo_full[k]),
            .pop       (out_ready[k]),
            .pop_data  (out_data[k*FLIT_WIDTH +: FLIT_WIDTH]),
            .valid     (out_valid[k])
        );
    end

endmodule

// File: tb/tb_config_router.sv
module tb_config_router;
    import config_router_pkg::*;

    localparam int FW = 512;
    localparam int NC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     in_config_data;
    logic              in_config_valid;
    logic              in_config_ready;
    logic [NC*FW-1:0]  out_data;
    logic [NC-1:0]     out_valid;
    logic [NC-1:0]     out_ready;
    logic              stats_clear;
    logic [31:0]       drop_count;
    logic [NC*32-1:0]  accept_count;
    logic              err_unknown_id;

    config_router dut (
        .clk             (clk),
        .rst             (rst),
        .in_config_data  (in_config_data),
        .in_config_valid (in_config_valid),
        .in_config_ready (in_config_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .stats_clear     (stats_clear),
        .drop_count      (drop_count),
        .accept_count    (accept_count),
        .err_unknown_id  (err_unknown_id)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   drops    = 0;
    logic err_m    = 1'b0;
    int   acc [NC] = '{0, 0, 0};

    typedef struct {
        logic [31:0] id;
        logic [31:0] payload;
        logic [2:0]  exp_valid;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [FW-1:0] mk(input logic [31:0] id, input logic [31:0] pl);
        return {id, pl, 416'h0, pl ^ 32'hA5A5_A5A5};
    endfunction

    function automatic logic [FW-1:0] ch_data(input int k);
        return out_data[k*FW +: FW];
    endfunction

    function automatic logic [31:0] ch_acc(input int k);
        return accept_count[k*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name);
        check({name, "_drop"}, 64'(drop_count), 64'(drops));
        check({name, "_err"}, 64'(err_unknown_id), 64'(err_m));
        for (int k = 0; k < NC; k++) begin
            check($sformatf("%s_acc%0d", name, k), 64'(ch_acc(k)), 64'(acc[k]));
        end
    endtask

    // Single flit with all consumers ready: accepted at once, visible one
    // cycle later on exactly the expected channels, then popped.
    task automatic send(input logic [31:0] id, input logic [31:0] pl,
                        input logic [2:0] exp_v, input string name);
        logic [FW-1:0] f;
        f = mk(id, pl);
        in_config_data  = f;
        in_config_valid = 1'b1;
        #1;
        check({name, "_ready"}, 64'(in_config_ready), 64'(1));
        tick();
        in_config_valid = 1'b0;
        check({name, "_valid"}, 64'(out_valid), 64'(exp_v));
        for (int k = 0; k < NC; k++) begin
            if (exp_v[k]) begin
                check_data($sformatf("%s_data%0d", name, k), ch_data(k), f);
                acc[k]++;
            end
        end
        if (exp_v == 3'b000) begin
            drops++;
            err_m = 1'b1;
        end
        check_counts(name);
        tick();
    endtask

    logic [FW-1:0] exp2 [4];
    int n;
    logic took;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{FLOW_TABLE_CONFIG_ID, 32'h0000_0011, 3'b001};
        vecs[1] = '{TIMESTAMP_CONFIG_ID,  32'h0000_0022, 3'b010};
        vecs[2] = '{RATE_LIMIT_CONFIG_ID, 32'h0000_0033, 3'b100};
        vecs[3] = '{CONFIG_BROADCAST_ID,  32'h0000_0044, 3'b111};
        vecs[4] = '{32'h0000_1234,        32'h0000_0055, 3'b000};
        vecs[5] = '{32'h0000_0000,        32'h0000_0066, 3'b000};

        rst             = 1'b0;
        in_config_data  = '0;
        in_config_valid = 1'b0;
        out_ready       = 3'b111;
        stats_clear     = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'(0));
        check_counts("rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'(0));

        // Table of single-flit routing cases
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].id, vecs[i].payload, vecs[i].exp_valid, $sformatf("vec%0d", i));
        end

        // Clear coinciding with a drop: clear wins
        in_config_data  = mk(32'h0000_1234, 32'h99);
        in_config_valid = 1'b1;
        stats_clear     = 1'b1;
        tick();
        in_config_valid = 1'b0;
        stats_clear     = 1'b0;
        drops = 0; err_m = 1'b0; acc = '{0, 0, 0};
        check_counts("clr_prio");

        send(32'h0000_1234, 32'h77, 3'b000, "unk");
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        drops = 0; err_m = 1'b0; acc = '{0, 0, 0};
        check_counts("clr");

        // Channel 1 stalled: four timestamp flits fill it, the fifth blocks
        out_ready = 3'b101;
        for (int i = 0; i < 4; i++) begin
            in_config_data  = mk(TIMESTAMP_CONFIG_ID, 32'd100 + 32'(i));
            in_config_valid = 1'b1;
            #1;
            check($sformatf("ts_fill%0d_ready", i), 64'(in_config_ready), 64'(1));
            tick();
        end
        in_config_data = mk(TIMESTAMP_CONFIG_ID, 32'd104);
        #1;
        check("ts_full_ready", 64'(in_config_ready), 64'(0));
        tick();
        check("ts_full_ready2", 64'(in_config_ready), 64'(0));
        check("ts_full_valid", 64'(out_valid), 64'(3'b010));
        out_ready = 3'b111;
        n = 0;
        took = 1'b0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            if (out_valid[1]) begin
                check_data($sformatf("ts_drain%0d", n), ch_data(1), mk(TIMESTAMP_CONFIG_ID, 32'd100 + 32'(n)));
                n++;
            end
            if (in_config_valid && in_config_ready) took = 1'b1;
            tick();
            if (took) in_config_valid = 1'b0;
        end
        check("ts_drain_count", 64'(n), 64'(5));
        acc[1] += 5;
        send(FLOW_TABLE_CONFIG_ID, 32'h0000_0abc, 3'b001, "after_ts");

        // Broadcast blocked by a full channel 2 until one pop frees a slot
        out_ready = 3'b011;
        for (int i = 0; i < 4; i++) begin
            in_config_data  = mk(RATE_LIMIT_CONFIG_ID, 32'd200 + 32'(i));
            exp2[i]         = in_config_data;
            in_config_valid = 1'b1;
            #1;
            check($sformatf("rl_fill%0d_ready", i), 64'(in_config_ready), 64'(1));
            tick();
        end
        acc[2] += 4;
        in_config_data = mk(CONFIG_BROADCAST_ID, 32'h0000_0b0b);
        #1;
        check("bc_blocked_ready", 64'(in_config_ready), 64'(0));
        tick();
        check("bc_blocked_ready2", 64'(in_config_ready), 64'(0));
        check("bc_no_partial", 64'(out_valid), 64'(3'b100));
        out_ready = 3'b111;
        tick();
        out_ready = 3'b011;
        #1;
        check("bc_after_pop_ready", 64'(in_config_ready), 64'(1));
        tick();
        in_config_valid = 1'b0;
        check("bc_valid", 64'(out_valid), 64'(3'b111));
        check_data("bc_data0", ch_data(0), mk(CONFIG_BROADCAST_ID, 32'h0000_0b0b));
        check_data("bc_data1", ch_data(1), mk(CONFIG_BROADCAST_ID, 32'h0000_0b0b));
        for (int k = 0; k < NC; k++) acc[k]++;
        check_counts("bc");
        exp2[0] = exp2[1]; exp2[1] = exp2[2]; exp2[2] = exp2[3];
        exp2[3] = mk(CONFIG_BROADCAST_ID, 32'h0000_0b0b);
        out_ready = 3'b111;
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            if (out_valid[2]) begin
                check_data($sformatf("rl_drain%0d", n), ch_data(2), exp2[n]);
                n++;
            end
            tick();
        end
        check("rl_drain_count", 64'(n), 64'(4));
        check("bc_all_empty", 64'(out_valid), 64'(0));

        // Streaming push and pop every cycle on channel 0 (pointer wrap)
        for (int i = 0; i <= 20; i++) begin
            in_config_valid = (i < 20);
            in_config_data  = mk(FLOW_TABLE_CONFIG_ID, 32'(i));
            #1;
            if (i < 20) check($sformatf("strm%0d_ready", i), 64'(in_config_ready), 64'(1));
            if (i >= 1) begin
                check($sformatf("strm%0d_valid", i), 64'(out_valid), 64'(3'b001));
                check_data($sformatf("strm%0d_data", i), ch_data(0), mk(FLOW_TABLE_CONFIG_ID, 32'(i - 1)));
            end
            @(posedge clk);
            #0;
        end
        in_config_valid = 1'b0;
        #1;
        check("strm_empty", 64'(out_valid), 64'(0));
        acc[0] += 20;
        check_counts("strm");

        // Asynchronous reset with two entries held in channel 0
        out_ready = 3'b000;
        for (int i = 0; i < 2; i++) begin
            in_config_data  = mk(FLOW_TABLE_CONFIG_ID, 32'd300 + 32'(i));
            in_config_valid = 1'b1;
            tick();
        end
        in_config_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'(3'b001));
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        drops = 0; err_m = 1'b0; acc = '{0, 0, 0};
        check_counts("async_rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rerst_valid", 64'(out_valid), 64'(0));
        out_ready = 3'b111;
        send(FLOW_TABLE_CONFIG_ID, 32'h0000_0777, 3'b001, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_router.md
Name: config_router

Overview:
- Parametrised successor to the fixed three-way configuration demux. Routes configuration flits from the PCIe/JTAG config path to NUM_CHANNELS consumers (flow table, timestamp, rate limiter, future blocks).
- Each channel has its own buffer, so backpressure from one consumer stalls only flits addressed to that consumer.
- Supports a broadcast ID.
- Drops unknown IDs and counts them instead of leaving them stuck.

Parameters:
- NUM_CHANNELS, 3: number of output channels (1..16).
- FLIT_WIDTH, 512: configuration flit width in bits.
- ID_LSB, 480: bit position of config_id within the flit.
- ID_WIDTH, 32: config_id width.
- CHANNEL_ID_MAP, {RATE_LIMIT_CONFIG_ID, TIMESTAMP_CONFIG_ID, FLOW_TABLE_CONFIG_ID}: NUM_CHANNELS*ID_WIDTH bits; channel k's ID is in slice k.
- BROADCAST_ID, 32'hFFFF_FFFF: ID delivered to every channel.
- FIFO_DEPTH, 4: per-channel buffer entries; power of two, at least 2.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-low reset.
- in_config_data, in, FLIT_WIDTH: input flit.
- in_config_valid, in, 1: input valid.
- in_config_ready, out, 1: input ready.
- out_data, out, NUM_CHANNELS*FLIT_WIDTH: per-channel flit, channel k in slice k.
- out_valid, out, NUM_CHANNELS: per-channel valid.
- out_ready, in, NUM_CHANNELS: per-channel ready.
- stats_clear, in, 1: synchronous clear of all counters.
- drop_count, out, 32: unknown-ID flits dropped; saturating.
- accept_count, out, NUM_CHANNELS*32: flits delivered into each channel FIFO; saturating.
- err_unknown_id, out, 1: sticky; set on first drop, cleared by stats_clear.

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-low.
  - Asserting rst low clears all FIFO pointers, counters and err_unknown_id immediately.
  - out_valid = 0 during reset and in the first cycle after rst deasserts.
  - out_data is don't-care while out_valid = 0.
- Decode (combinational on in_config_data.config_id):
  - match[k] = (id == CHANNEL_ID_MAP[k]).
  - bcast = (id == BROADCAST_ID).
  - unknown = none of the above.
  - If one ID appears in several map slices, all matching channels receive the flit, with broadcast semantics.
- in_config_ready:
  - Unknown ID: 1.
  - Otherwise: AND of !full[k] over every targeted k.
  - Ready never depends combinationally on out_ready, because full is registered. A full FIFO refuses a push even if it pops in the same cycle.
- Accept: when in_config_valid && in_config_ready, the flit is pushed to every targeted FIFO in the same cycle, atomically. A broadcast is never partially delivered.
- Drop: an accepted unknown ID is pushed nowhere.
  - drop_count increments and err_unknown_id sets.
  - No other side effects.
- Latency: a flit accepted in cycle N is presented with out_valid[k] = 1 in cycle N+1 at the earliest. There is no fall-through.
- Output handshake: each channel is standard valid/ready.
  - Pop when out_valid[k] && out_ready[k].
  - Once asserted, data and valid stay stable until the pop.
- FIFO: read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Simultaneous push and pop on an empty FIFO: push accepted, nothing popped.
  - Ordering within a channel is preserved.
  - No ordering guarantee across channels.
- Counters: 32-bit saturating at 32'hFFFF_FFFF.
  - stats_clear has priority over a simultaneous increment; counters read 0 the next cycle.
- In-flight state at reset is lost. No partial flits exist, since one flit is one beat.

Decomposition:
- Shared package (constants.sv), additions:
  - CONFIG_BROADCAST_ID.
  - CONFIG_ID_LSB, CONFIG_ID_WIDTH.
  - NUM_CONFIG_CHANNELS.
  - Default CHANNEL_ID_MAP built from the existing FLOW_TABLE/TIMESTAMP/RATE_LIMIT config ID constants.
- config_flit_t stays in the package. The router treats it as an opaque FLIT_WIDTH vector; per-channel typed casts are done by the instantiating top level.
- One sub-module: config_fifo (parameters WIDTH, DEPTH; registered-output FIFO with full/empty and push/pop), instantiated NUM_CHANNELS times via generate.

Test Plan:
- Flit with the FLOW_TABLE ID, all out_ready = 1:
  - out_valid = 3'b001 exactly one cycle after acceptance; data bit-exact.
  - accept_count[0] = 1.
- Channel 1 out_ready = 0, five TIMESTAMP flits sent (FIFO_DEPTH = 4):
  - Four accepted, then in_config_ready = 0.
  - A following FLOW_TABLE flit is still blocked behind it (in-order input).
  - After out_ready[1] = 1, all five drain in order.
- ID 32'h1234 with no map match:
  - Accepted in one cycle; no out_valid.
  - drop_count = 1, err_unknown_id = 1.
  - stats_clear then gives 0/0.
- BROADCAST_ID with channel 2 full:
  - in_config_ready = 0 and no channel receives it.
  - After one pop on channel 2: accepted, and all three out_valid assert the next cycle.
- Push/pop every cycle for 20 flits on channel 0 (pointer wrap, ≥5 wraps):
  - Data sequence 0..19 out in order; no spurious full or empty.
- rst pulled low mid-stream with FIFOs holding 2 entries:
  - out_valid = 0 immediately (asynchronous); counters = 0.
  - After release, the first new flit is delivered with the 1-cycle latency.
